// File: rtl/alu_arb_pkg.sv
// Shared types and ALU encodings for the two-requester ALU arbiter.
// Pure declarations: no latency, no flow control.
// Consumed by alu_rr_pick, alu_share_arbiter and their bench.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_SLT = 3'b010;
  localparam logic [2:0] FUNCT3_OR  = 3'b110;
  localparam logic [2:0] FUNCT3_AND = 3'b111;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: one-hot grant from valid, rr_ptr breaks ties.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is honoured.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (valid == 2'b11) begin
      gnt = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = valid;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between two requesters; optional grant counters under ALU_ARB_STATS_EN.
// Latency: grant at edge N, registered result valid after edge N+2; one operation in flight.
// Backpressure: result is held in RESP until the owner's resp_ready; no new grants meanwhile.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_srca,
  input  logic [DATA_W-1:0] req0_srcb,
  input  logic [2:0]        req0_funct3,
  input  logic [1:0]        req0_aluop,
  input  logic [DATA_W-1:0] req1_srca,
  input  logic [DATA_W-1:0] req1_srcb,
  input  logic [2:0]        req1_funct3,
  input  logic [1:0]        req1_aluop,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [2:0]        alu_funct3,
  output logic [1:0]        alu_aluop,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              owner;
  logic [DATA_W-1:0] op_srca, op_srcb;
  logic [2:0]        op_funct3;
  logic [1:0]        op_aluop;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              resp_done;

  alu_rr_pick u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (gnt)
  );

  assign grant_en  = |req_ready;
  assign resp_done = (state == RESP) && resp_ready[owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_en) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst gating keeps req_ready and the ALU bus quiet during the reset cycle itself.
  always_comb begin
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_srca   = '0;
    alu_srcb   = '0;
    alu_funct3 = 3'b000;
    alu_aluop  = 2'b00;
    case (state)
      IDLE: if (!rst) req_ready = gnt;
      EXEC: begin
        if (!rst) begin
          alu_srca   = op_srca;
          alu_srcb   = op_srcb;
          alu_funct3 = op_funct3;
          alu_aluop  = op_aluop;
        end
      end
      RESP:    resp_valid = owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      op_srca     <= '0;
      op_srcb     <= '0;
      op_funct3   <= 3'b000;
      op_aluop    <= 2'b00;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (grant_en) begin
        owner     <= req_ready[1];
        op_srca   <= req_ready[1] ? req1_srca   : req0_srca;
        op_srcb   <= req_ready[1] ? req1_srcb   : req0_srcb;
        op_funct3 <= req_ready[1] ? req1_funct3 : req0_funct3;
        op_aluop  <= req_ready[1] ? req1_aluop  : req0_aluop;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
      end
      // The pointer only moves once a result is consumed, so a served requester yields next tie.
      if (resp_done) begin
        rr_ptr <= ~owner;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && (grant_cnt0 != {CNT_W{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && (grant_cnt1 != {CNT_W{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter with a transaction-level reference model and a behavioural ALU.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int DW = 32;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]    req0_funct3, req1_funct3, alu_funct3;
  logic [1:0]    req0_aluop, req1_aluop, alu_aluop;
  logic [DW-1:0] resp_result, alu_srca, alu_srcb, alu_result;
  logic          resp_zero, alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_funct3(req0_funct3), .req0_aluop(req0_aluop),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_funct3(req1_funct3), .req1_aluop(req1_aluop),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_funct3(alu_funct3), .alu_aluop(alu_aluop),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Behavioural ALU: the external instance the arbiter feeds, also used for expected results.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [2:0] f3, input logic [1:0] op);
    if (op == ALUOP_ADD) return a + b;
    if (op == ALUOP_SUB) return a - b;
    case (f3)
      FUNCT3_SLT: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      FUNCT3_OR:  return a | b;
      FUNCT3_AND: return a & b;
      default:    return a + b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_srcb, alu_funct3, alu_aluop);
  assign alu_zero   = (alu_result == '0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: pending ops per requester, tie-break favourite, grant counts.
  logic [1:0]    pend;
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [2];
  logic [2:0]    pf [2];
  logic [1:0]    po [2];
  logic          favour;
  int            m_cnt [2];
  int            last_owner;
  logic [DW-1:0] last_res;
  logic          last_zero;

  task automatic drive();
    req_valid   = pend;
    req0_srca   = pa[0]; req0_srcb = pb[0]; req0_funct3 = pf[0]; req0_aluop = po[0];
    req1_srca   = pa[1]; req1_srcb = pb[1]; req1_funct3 = pf[1]; req1_aluop = po[1];
  endtask

  task automatic set_op(input int w, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [2:0] f3, input logic [1:0] op);
    pa[w] = a; pb[w] = b; pf[w] = f3; po[w] = op;
    pend[w] = 1'b1;
  endtask

  task automatic new_op(input int w);
    logic [2:0] f3s [4];
    logic [DW-1:0] a, b;
    f3s[0] = FUNCT3_ADD; f3s[1] = FUNCT3_SLT; f3s[2] = FUNCT3_OR; f3s[3] = FUNCT3_AND;
    a = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 4));
    b = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 4));
    set_op(w, a, b, f3s[$urandom_range(0, 3)], 2'($urandom_range(0, 2)));
  endtask

  task automatic do_reset();
    rst = 1'b1; pend = 2'b00; resp_ready = 2'b00; drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    favour = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // One arbitration slot, entered and left at posedge+1 with the DUT idle.
  task automatic step(input int bp, input bit refill);
    logic [1:0]    g, oh;
    logic [DW-1:0] er, sa;
    logic          ez;
    logic [1:0]    so;
    int            w;
    @(negedge clk);
    g = (pend == 2'b11) ? (favour ? 2'b10 : 2'b01) : pend;
    check("req_ready", DW'(req_ready), DW'(g));
    check("idle_resp_valid", DW'(resp_valid), '0);
    if (g == 2'b00) begin
      @(posedge clk); #1;
    end else begin
      w  = g[1] ? 1 : 0;
      oh = g;
      er = alu_fn(pa[w], pb[w], pf[w], po[w]);
      ez = (er == '0);
      sa = pa[w]; so = po[w];
      @(posedge clk); #1;
      if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
      pend[w] = 1'b0;
      if (refill) new_op(w);
      drive();
      @(negedge clk);
      check("exec_req_ready", DW'(req_ready), '0);
      check("exec_resp_valid", DW'(resp_valid), '0);
      check("alu_srca", alu_srca, sa);
      check("alu_aluop", DW'(alu_aluop), DW'(so));
`ifdef ALU_ARB_STATS_EN
      check("grant_cnt0", DW'(grant_cnt0), DW'(m_cnt[0]));
      check("grant_cnt1", DW'(grant_cnt1), DW'(m_cnt[1]));
`endif
      @(posedge clk); #1;
      for (int i = 0; i <= bp; i++) begin
        resp_ready = (i == bp) ? oh : 2'b00;
        resp_ready = resp_ready | (~oh & 2'($urandom_range(0, 3)));
        @(negedge clk);
        check("resp_valid", DW'(resp_valid), DW'(oh));
        check("resp_result", resp_result, er);
        check("resp_zero", DW'(resp_zero), DW'(ez));
        check("resp_req_ready", DW'(req_ready), '0);
        last_res = resp_result; last_zero = resp_zero;
        @(posedge clk); #1;
      end
      resp_ready = 2'b00;
      favour = (w == 0);
      last_owner = w;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0; pb[i] = '0; pf[i] = '0; po[i] = '0;
    end
    last_owner = -1; last_res = '0; last_zero = 1'b0;
    rst = 1'b1; pend = 2'b00; resp_ready = 2'b00;
    set_op(0, 32'd10, 32'd20, FUNCT3_ADD, ALUOP_ADD);
    drive();
    @(negedge clk);
    check("rst_req_ready", DW'(req_ready), '0);
    @(posedge clk); #1;
    rst = 1'b0; favour = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    pend = 2'b00; drive();
    @(negedge clk);
    check("rst_resp_valid", DW'(resp_valid), '0);
    check("rst_resp_result", resp_result, '0);
    check("rst_resp_zero", DW'(resp_zero), '0);
    check("rst_alu_srca", alu_srca, '0);
    @(posedge clk); #1;

    // Single ADD, then SUB producing zero on requester 1.
    set_op(0, 32'd10, 32'd20, FUNCT3_ADD, ALUOP_ADD); drive();
    step(0, 0);
    check("add_result", last_res, 32'd30);
    check("add_zero", DW'(last_zero), '0);
    set_op(1, 32'd30, 32'd30, FUNCT3_ADD, ALUOP_SUB); drive();
    step(0, 0);
    check("sub_owner", DW'(last_owner), 32'd1);
    check("sub_zero", DW'(last_zero), 32'd1);

    // Contention right after reset: req0 first, then req1.
    do_reset();
    set_op(0, 32'hFF, 32'hAA, FUNCT3_OR, ALUOP_FUNCT);
    set_op(1, 32'hF0, 32'h0F, FUNCT3_AND, ALUOP_FUNCT);
    drive();
    step(0, 0);
    check("cont_first_owner", DW'(last_owner), 32'd0);
    check("cont_first_result", last_res, 32'hFF);
    step(0, 0);
    check("cont_second_owner", DW'(last_owner), 32'd1);
    check("cont_second_zero", DW'(last_zero), 32'd1);

    // Backpressure with both requesters still valid.
    new_op(0); new_op(1); drive();
    step(5, 1);

    // Reset during EXEC while rr_ptr favours requester 1.
    do_reset();
    new_op(0); drive();
    step(0, 0);
    new_op(0); new_op(1); drive();
    @(negedge clk);
    check("pre_rst_grant", DW'(req_ready), 32'd2);
    @(posedge clk); #1;
    pend[1] = 1'b0; rst = 1'b1; drive();
    @(negedge clk);
    check("mid_rst_req_ready", DW'(req_ready), '0);
    check("mid_rst_alu_srca", alu_srca, '0);
    @(posedge clk); #1;
    rst = 1'b0; favour = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    new_op(1); drive();
    step(0, 0);
    check("post_rst_owner", DW'(last_owner), 32'd0);

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      new_op(i < 3 ? 0 : 1); drive();
      step(0, 0);
    end
    @(negedge clk);
    check("stats_cnt0", DW'(grant_cnt0), 32'd3);
    check("stats_cnt1", DW'(grant_cnt1), 32'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      new_op(0); drive();
      step(0, 0);
    end
    @(negedge clk);
    check("stats_sat0", DW'(grant_cnt0), 32'd3);
    @(posedge clk); #1;
`endif

    // Random traffic.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int w = 0; w < 2; w++) begin
        if (!pend[w] && ($urandom_range(0, 2) != 0)) new_op(w);
      end
      drive();
      step($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. execute-stage datapath (req 0) and a multi-cycle helper such as address/branch-compare sequencing (req 1).
- Accepts operand bundles over valid/ready, arbitrates round-robin, drives the ALU from registered operands, registers the result and returns it over a per-requester valid/ready response.
- Sits between the requesters and the existing ALU; the ALU stays an external instance.

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 16, width of the grant counters (used only with ALU_ARB_STATS_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  bit i = requester i presents an operation
- req_ready  out  2  bit i = operation i accepted this cycle (one-hot or zero)
- req0_srca, req0_srcb  in  DATA_W  requester 0 operands
- req0_funct3  in  3  requester 0 funct3
- req0_aluop  in  2  requester 0 ALUOp
- req1_srca, req1_srcb, req1_funct3, req1_aluop  in  DATA_W/DATA_W/3/2  requester 1 operation
- resp_valid  out  2  bit i = result for requester i is available
- resp_ready  in  2  bit i = requester i takes the result
- resp_result  out  DATA_W  registered ALU result (shared bus)
- resp_zero  out  1  registered ALU zero flag
- alu_srca, alu_srcb  out  DATA_W  to ALU SrcA/SrcB
- alu_funct3  out  3  to ALU funct3
- alu_aluop  out  2  to ALU ALUOp
- alu_result  in  DATA_W  from ALU ALU_result
- alu_zero  in  1  from ALU zero

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0 (requester 0 favoured), owner=0.
  - Operand registers and resp_result cleared to 0; resp_zero=0; resp_valid=00.
  - req_ready=00 while rst is high; alu_* outputs are 0.
- IDLE:
  - req_ready is combinational: if exactly one req_valid bit is set, that bit is granted. If both are set, the rr_ptr requester is granted.
  - On a grant: latch that requester's srca/srcb/funct3/aluop into the operand registers, set owner, go to EXEC.
  - No valid: stay in IDLE.
  - alu_* outputs are 0 in IDLE.
- EXEC:
  - alu_* driven from the operand registers.
  - At the clock edge: resp_result<=alu_result, resp_zero<=alu_zero; go to RESP.
- RESP:
  - resp_valid[owner]=1, other bit 0; resp_result/resp_zero held stable.
  - When resp_ready[owner]=1: go to IDLE and set rr_ptr to ~owner.
  - resp_ready on the non-owner bit is ignored.
  - req_ready=00 in EXEC and RESP.
- Latency: grant at edge N, resp_valid high after edge N+2. Minimum 3 cycles per operation; no overlap.
- Requester rules: hold req_* stable until granted; must not drop valid before ready. The arbiter does not check this.
- Width: pass-through only. Arithmetic is the ALU's job; no sign/width conversion.
- Simultaneous requests: strict alternation while both stay valid (0,1,0,1… from reset).
- Reset mid-operation: a pending operation is discarded; resp_valid=00 the cycle after reset.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on every grant to its requester and saturates at all-ones.
  - Both clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_arb_pkg:
  - state enum (IDLE/EXEC/RESP)
  - ALUOp constants: 00 ADD, 01 SUB, 10 funct3-decoded
  - funct3 constants: 000 ADD, 010 SLT, 110 OR, 111 AND
- Sub-module alu_rr_pick:
  - 2-way round-robin picker, combinational.
  - Inputs: valid[1:0], rr_ptr. Outputs: one-hot gnt[1:0].
  - Unit-testable alone.

Test Plan:
- Single ADD: req0 valid, srca=10, srcb=20, aluop=00, funct3=000 → req_ready=01 the same cycle; resp_valid=01 two edges later; resp_result=30, resp_zero=0.
- Zero flag: req1 SUB, srca=30, srcb=30, aluop=01 → resp_valid=10, resp_result=0, resp_zero=1.
- Contention: right after reset both valid (req0 OR 0xFF|0xAA, req1 AND 0xF0&0x0F), resp_ready=11:
  - req0 is served first: 0xFF.
  - req1 is served next: 0x00, zero=1.
  - Grant order is 0,1.
- Backpressure: resp_ready=00 for 5 cycles in RESP → resp_valid and resp_result are stable; req_ready stays 00 although req_valid=11.
- Reset mid-op: assert rst during EXEC or RESP → the next cycle has resp_valid=00 and state IDLE; the next grant goes to req0.
- Stats (ALU_ARB_STATS_EN): 3 req0 ops plus 2 req1 ops → grant_cnt0=3, grant_cnt1=2. With CNT_W=2, 5 req0 ops → grant_cnt0=3 (saturated).
